// File: rtl/led_blink_unit.sv
// LED blinker: four free-running square-wave generators, a 2-bit rate select
// and an enable gate feeding one registered LED output.
module led_blink_unit #(
    parameter int HALF_100HZ = 250_000,
    parameter int HALF_50HZ  = 500_000,
    parameter int HALF_10HZ  = 2_500_000,
    parameter int HALF_1HZ   = 25_000_000,
    parameter int CNT_W      = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic sw1,
    input  logic sw2,
    output logic led
);

    localparam logic [CNT_W-1:0] LAST_100 = CNT_W'(HALF_100HZ - 1);
    localparam logic [CNT_W-1:0] LAST_50  = CNT_W'(HALF_50HZ - 1);
    localparam logic [CNT_W-1:0] LAST_10  = CNT_W'(HALF_10HZ - 1);
    localparam logic [CNT_W-1:0] LAST_1   = CNT_W'(HALF_1HZ - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_100_q, cnt_100_d;
    logic [CNT_W-1:0] cnt_50_q,  cnt_50_d;
    logic [CNT_W-1:0] cnt_10_q,  cnt_10_d;
    logic [CNT_W-1:0] cnt_1_q,   cnt_1_d;
    logic             tog_100_q, tog_100_d;
    logic             tog_50_q,  tog_50_d;
    logic             tog_10_q,  tog_10_d;
    logic             tog_1_q,   tog_1_d;
    logic             led_q,     led_d;
    logic             sel_tog;

    // Each generator wraps on exact equality with its last count and flips its toggle.
    always_comb begin
        cnt_100_d = cnt_100_q + CNT_ONE;
        tog_100_d = tog_100_q;
        if (cnt_100_q == LAST_100) begin
            cnt_100_d = '0;
            tog_100_d = ~tog_100_q;
        end

        cnt_50_d = cnt_50_q + CNT_ONE;
        tog_50_d = tog_50_q;
        if (cnt_50_q == LAST_50) begin
            cnt_50_d = '0;
            tog_50_d = ~tog_50_q;
        end

        cnt_10_d = cnt_10_q + CNT_ONE;
        tog_10_d = tog_10_q;
        if (cnt_10_q == LAST_10) begin
            cnt_10_d = '0;
            tog_10_d = ~tog_10_q;
        end

        cnt_1_d = cnt_1_q + CNT_ONE;
        tog_1_d = tog_1_q;
        if (cnt_1_q == LAST_1) begin
            cnt_1_d = '0;
            tog_1_d = ~tog_1_q;
        end
    end

    always_comb begin
        sel_tog = tog_100_q;
        unique case ({sw1, sw2})
            2'b00:   sel_tog = tog_100_q;
            2'b01:   sel_tog = tog_50_q;
            2'b10:   sel_tog = tog_10_q;
            2'b11:   sel_tog = tog_1_q;
            default: sel_tog = tog_100_q;
        endcase
        led_d = enable & sel_tog;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_100_q <= '0;
            cnt_50_q  <= '0;
            cnt_10_q  <= '0;
            cnt_1_q   <= '0;
            tog_100_q <= 1'b0;
            tog_50_q  <= 1'b0;
            tog_10_q  <= 1'b0;
            tog_1_q   <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            cnt_100_q <= cnt_100_d;
            cnt_50_q  <= cnt_50_d;
            cnt_10_q  <= cnt_10_d;
            cnt_1_q   <= cnt_1_d;
            tog_100_q <= tog_100_d;
            tog_50_q  <= tog_50_d;
            tog_10_q  <= tog_10_d;
            tog_1_q   <= tog_1_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_blink_unit.sv
// Directed bench for led_blink_unit using shortened half-periods 4/8/16/32.
module tb_led_blink_unit;

    localparam int H100 = 4;
    localparam int H50  = 8;
    localparam int H10  = 16;
    localparam int H1   = 32;

    logic clock;
    logic reset;
    logic enable;
    logic sw1;
    logic sw2;
    logic led;

    int checks;
    int passes;
    int edges;
    int high_cnt;
    logic exp_led;

    led_blink_unit #(
        .HALF_100HZ(H100),
        .HALF_50HZ (H50),
        .HALF_10HZ (H10),
        .HALF_1HZ  (H1),
        .CNT_W     (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .sw1   (sw1),
        .sw2   (sw2),
        .led   (led)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    // Toggle value after e non-reset edges: flips once every half clocks.
    function automatic logic tog_after(int half, int e);
        return ((e / half) % 2) == 1;
    endfunction

    function automatic logic sel_model(logic s1, logic s2, int e);
        case ({s1, s2})
            2'b00:   return tog_after(H100, e);
            2'b01:   return tog_after(H50, e);
            2'b10:   return tog_after(H10, e);
            default: return tog_after(H1, e);
        endcase
    endfunction

    task automatic check_output(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: observed=%b expected=%b (edges=%0d)", tag, obs, exp, edges);
        end
    endtask

    // Drive inputs, take one rising edge, then compare led against the model.
    task automatic apply_stimulus(input logic rst, input logic en, input logic s1, input logic s2,
                                  input string tag);
        reset  = rst;
        enable = en;
        sw1    = s1;
        sw2    = s2;
        @(posedge clock);
        #1;
        if (rst) begin
            exp_led = 1'b0;
            edges   = 0;
        end else begin
            exp_led = en & sel_model(s1, s2, edges);
            edges++;
        end
        if (led === 1'b1) high_cnt++;
        check_output(tag, led, exp_led);
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        edges    = 0;
        high_cnt = 0;
        exp_led  = 1'b0;
        reset    = 1'b1;
        enable   = 1'b1;
        sw1      = 1'b0;
        sw2      = 1'b0;

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, "reset_led");
        check_output("reset_cnt100", dut.cnt_100_q == 0, 1'b1);
        check_output("reset_cnt1", dut.cnt_1_q == 0, 1'b1);

        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "rate100_lead");
        check_output("pre_first_rise", led, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "rate100_rise");
        check_output("first_rise_edge5", led, 1'b1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "rate100_high");
        check_output("first_fall_pending", led, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "rate100_fall");
        check_output("first_fall_edge9", led, 1'b0);
        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "rate100");

        high_cnt = 0;
        for (int i = 0; i < 48; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, "rate50");
        check_output("duty50", high_cnt == 24, 1'b1);

        high_cnt = 0;
        for (int i = 0; i < 96; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, "rate10");
        check_output("duty10", high_cnt == 48, 1'b1);

        high_cnt = 0;
        for (int i = 0; i < 192; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, "rate1");
        check_output("duty1", high_cnt == 96, 1'b1);

        for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, "disabled");
        for (int i = 0; i < 40; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, "reenabled");

        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "pre_switch");
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, "post_switch");

        for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, "mid_reset");
        check_output("mid_reset_led", led, 1'b0);
        check_output("mid_reset_cnt10", dut.cnt_10_q == 0, 1'b1);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "restart_lead");
        check_output("restart_pre_rise", led, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "restart_rise");
        check_output("restart_rise_edge5", led, 1'b1);
        for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "restart_run");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
